instruction_fetch_unit: RTL and testbench

Producer side of the instruction register interface in the multicycle core. Holds the program counter, issues a read request to instruction memory, waits for the response, and drives `instr_data` plus the 2-bit `ir_control` word so the instruction register latches exactly one new instruction per fetch. It is started by the control unit and redirected by branch/jump resolution.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/program_counter.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its program counter.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOAD,
        FAULT
    } fetch_state_t;

    localparam logic [1:0]  IR_CTRL_HOLD     = 2'b00;
    localparam logic [1:0]  IR_CTRL_LOAD     = 2'b01;
    localparam logic [1:0]  IR_CTRL_CLEAR    = 2'b10;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/program_counter.sv
// Program counter register with a redirect load port and a +4 increment port.
module program_counter
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] pc_next,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q;

    // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
    assign pc_plus4 = pc_q + 32'd4;
    assign pc       = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_next;
        end else if (inc) begin
            pc_q <= pc_plus4;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multicycle fetch: requests the word at PC, buffers the response and issues one IR load.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_data,
    output logic [1:0]  ir_control,
    output logic        fetch_done,
    output logic        fetch_fault,
    output logic        busy
);

    fetch_state_t state_q, state_d;
    logic [31:0]  instr_buf_q, instr_buf_d;
    logic         fault_seen_q;
    logic         pc_load_en;
    logic         pc_inc;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load_en),
        .inc      (pc_inc),
        .pc_next  (pc_next),
        .pc       (pc_out),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_buf_q  <= 32'h0;
            fault_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_buf_q  <= instr_buf_d;
            fault_seen_q <= (state_q == FAULT);
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_buf_d = instr_buf_q;
        pc_load_en  = 1'b0;
        pc_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A redirect wins over a simultaneous fetch request, which is dropped.
                if (pc_load) begin
                    pc_load_en = 1'b1;
                end else if (fetch_start) begin
                    state_d = (pc_out[1:0] == 2'b00) ? REQ : FAULT;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    instr_buf_d = mem_rdata;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                pc_inc  = 1'b1;
                state_d = IDLE;
            end
            FAULT: begin
                if (pc_load) begin
                    pc_load_en = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ir_control = IR_CTRL_HOLD;
        if (reset) begin
            ir_control = IR_CTRL_CLEAR;
        end else if (state_q == LOAD) begin
            ir_control = IR_CTRL_LOAD;
        end else if (state_q == FAULT && !fault_seen_q) begin
            ir_control = IR_CTRL_CLEAR;
        end
    end

    assign mem_req     = (state_q == REQ) && !reset;
    assign mem_addr    = pc_out;
    assign instr_data  = instr_buf_q;
    assign fetch_done  = (state_q == LOAD);
    assign fetch_fault = (state_q == FAULT);
    assign busy        = (state_q != IDLE) && (state_q != FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr_data;
    logic [1:0]  ir_control;
    logic        fetch_done;
    logic        fetch_fault;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_data  (instr_data),
        .ir_control  (ir_control),
        .fetch_done  (fetch_done),
        .fetch_fault (fetch_fault),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Best-case fetch; entered just after a negedge with the unit in IDLE.
    task automatic fetch_best(input logic [31:0] addr, input logic [31:0] data);
        fetch_start = 1'b1;
        mem_ready   = 1'b1;
        @(negedge clk);
        check("req_mem_req", 32'(mem_req), 32'd1);
        check("req_addr", mem_addr, addr);
        check("req_busy", 32'(busy), 32'd1);
        fetch_start = 1'b0;
        mem_rvalid  = 1'b0;
        @(negedge clk);
        check("wait_mem_req", 32'(mem_req), 32'd0);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        check("load_ir", 32'(ir_control), 32'd1);
        check("load_done", 32'(fetch_done), 32'd1);
        check("load_data", instr_data, data);
        check("load_pc", pc_out, addr);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("post_ir", 32'(ir_control), 32'd0);
        check("post_done", 32'(fetch_done), 32'd0);
        check("post_pc", pc_out, addr + 32'd4);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_next     = 32'h0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;

        @(negedge clk);
        check("rst_ir", 32'(ir_control), 32'd2);
        check("rst_pc", pc_out, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_instr", instr_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ir", 32'(ir_control), 32'd0);

        // Best case
        fetch_best(32'h0, 32'h0000_0093);
        check("best_plus4", pc_plus4, 32'd8);

        // Stalled memory: REQ cycles 1..4, WAIT 5..9, LOAD at 10
        fetch_start = 1'b1;
        mem_ready   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", mem_addr, 32'h4);
            check("stall_busy", 32'(busy), 32'd1);
            fetch_start = 1'b0;
            mem_ready   = (i == 4);
            // Illegal same-cycle rvalid on acceptance must be ignored
            mem_rvalid  = (i == 4);
            mem_rdata   = 32'hDEAD_BEEF;
        end
        for (int i = 5; i <= 9; i++) begin
            @(negedge clk);
            check("wait_req", 32'(mem_req), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_ir", 32'(ir_control), 32'd0);
            check("wait_buf", instr_data, 32'h0000_0093);
            mem_ready  = 1'b0;
            mem_rvalid = (i == 9);
            mem_rdata  = (i == 9) ? 32'h00A0_0113 : 32'hDEAD_BEEF;
            pc_load    = (i == 6);
            pc_next    = 32'h0000_0200;
        end
        @(negedge clk);
        check("stall_done", 32'(fetch_done), 32'd1);
        check("stall_data", instr_data, 32'h00A0_0113);
        check("stall_pc_wait_load", pc_out, 32'h4);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stall_pc_after", pc_out, 32'h8);
        check("stall_idle", 32'(busy), 32'd0);

        // Redirect beats fetch_start
        pc_load     = 1'b1;
        pc_next     = 32'h0000_0100;
        fetch_start = 1'b1;
        @(negedge clk);
        check("redir_pc", pc_out, 32'h100);
        check("redir_req", 32'(mem_req), 32'd0);
        check("redir_busy", 32'(busy), 32'd0);
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        @(negedge clk);
        check("redir_req2", 32'(mem_req), 32'd0);

        // Misaligned
        pc_load = 1'b1;
        pc_next = 32'h0000_0102;
        @(negedge clk);
        check("mis_pc", pc_out, 32'h102);
        pc_load     = 1'b0;
        fetch_start = 1'b1;
        @(negedge clk);
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_ir_clear", 32'(ir_control), 32'd2);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_busy", 32'(busy), 32'd0);
        fetch_start = 1'b0;
        @(negedge clk);
        check("mis_ir_hold", 32'(ir_control), 32'd0);
        check("mis_fault_held", 32'(fetch_fault), 32'd1);
        @(negedge clk);
        check("mis_fault_held2", 32'(fetch_fault), 32'd1);
        check("mis_req2", 32'(mem_req), 32'd0);
        pc_load = 1'b1;
        pc_next = 32'h0000_0104;
        @(negedge clk);
        check("mis_exit", 32'(fetch_fault), 32'd0);
        check("mis_new_pc", pc_out, 32'h104);
        pc_load = 1'b0;
        fetch_best(32'h104, 32'h0000_0513);

        // Wrap-around
        pc_load = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_pre_plus4", pc_plus4, 32'h0);
        pc_load = 1'b0;
        fetch_best(32'hFFFF_FFFC, 32'h0010_0073);
        check("wrap_plus4", pc_plus4, 32'h4);

        // Reset during REQ drops mem_req asynchronously
        pc_load = 1'b1;
        pc_next = 32'h0000_0040;
        @(negedge clk);
        pc_load     = 1'b0;
        fetch_start = 1'b1;
        mem_ready   = 1'b0;
        @(negedge clk);
        check("areq_req", 32'(mem_req), 32'd1);
        fetch_start = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("areq_req_drop", 32'(mem_req), 32'd0);
        check("areq_ir", 32'(ir_control), 32'd2);
        check("areq_pc", pc_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-WAIT, then a stray rvalid
        @(negedge clk);
        fetch_start = 1'b1;
        mem_ready   = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        check("rwait_busy", 32'(busy), 32'd1);
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rwait_busy_drop", 32'(busy), 32'd0);
        check("rwait_ir", 32'(ir_control), 32'd2);
        check("rwait_pc", pc_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_C0DE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_ir", 32'(ir_control), 32'd0);
        check("stray_done", 32'(fetch_done), 32'd0);
        check("stray_buf", instr_data, 32'h0);
        @(negedge clk);
        check("stray_done2", 32'(fetch_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
